// File: rtl/layer_serializer_pkg.sv
// Shared types and helpers for the layer serializer and later output stages.
package layer_serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  // Index width that stays at least one bit wide for tiny layers.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/layer_serializer_if.sv
// Bundle of the parallel-in / serial-out signals around one layer_serializer.
interface layer_serializer_if
  import layer_serializer_pkg::*;
#(
  parameter int neurons   = 16,
  parameter int dataWidth = 16
);
  localparam int IDXW = idx_width(neurons);

  logic [neurons-1:0]           in_valid;
  logic [neurons*dataWidth-1:0] in_data;
  logic                         clr_err;
  logic                         out_valid;
  logic [dataWidth-1:0]         out_data;
  logic                         out_last;
  logic [IDXW-1:0]              word_idx;
  logic                         overrun_err;
  logic                         mismatch_err;

  modport master (
    output in_valid, in_data, clr_err,
    input  out_valid, out_data, out_last, word_idx, overrun_err, mismatch_err
  );

  modport slave (
    input  in_valid, in_data, clr_err,
    output out_valid, out_data, out_last, word_idx, overrun_err, mismatch_err
  );
endinterface

// File: rtl/layer_serializer.sv
// Captures a full layer output vector and replays it one word per clock,
// framed by word_idx/out_last, with sticky overrun and ragged-valid flags.
module layer_serializer
  import layer_serializer_pkg::*;
#(
  parameter int neurons   = 16,
  parameter int dataWidth = 16
) (
  input logic               clk,
  input logic               rst_n,
  layer_serializer_if.slave bus
);
  localparam int IDXW = idx_width(neurons);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(neurons - 1);

  ser_state_t                   state, state_next;
  logic [neurons*dataWidth-1:0] shreg;
  logic [IDXW-1:0]              cnt;
  logic                         last_q;
  logic                         overrun_q;
  logic                         mismatch_q;

  logic cap;
  logic at_last;
  logic set_overrun;
  logic set_mismatch;

  assign cap          = bus.in_valid[0];
  assign at_last      = (cnt == LAST_IDX);
  assign set_overrun  = (state == SHIFT) && !at_last && cap;
  assign set_mismatch = (bus.in_valid != '0) && (bus.in_valid != '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cap) state_next = SHIFT;
      SHIFT:   if (at_last && !cap) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A capture is only accepted when idle or while the final word is on the bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg  <= '0;
      cnt    <= '0;
      last_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cap) begin
            shreg  <= bus.in_data;
            cnt    <= '0;
            last_q <= 1'b0;
          end
        end
        SHIFT: begin
          if (at_last) begin
            shreg  <= cap ? bus.in_data : '0;
            cnt    <= '0;
            last_q <= 1'b0;
          end else begin
            shreg  <= shreg >> dataWidth;
            cnt    <= cnt + IDXW'(1);
            last_q <= ((cnt + IDXW'(1)) == LAST_IDX);
          end
        end
        default: begin
          shreg  <= '0;
          cnt    <= '0;
          last_q <= 1'b0;
        end
      endcase
    end
  end

  // Sticky flags: a set in the same cycle wins over the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_q  <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      if (set_overrun)      overrun_q <= 1'b1;
      else if (bus.clr_err) overrun_q <= 1'b0;

      if (set_mismatch)     mismatch_q <= 1'b1;
      else if (bus.clr_err) mismatch_q <= 1'b0;
    end
  end

  always_comb begin
    bus.out_valid    = (state == SHIFT);
    bus.out_data     = (state == SHIFT) ? shreg[dataWidth-1:0] : '0;
    bus.word_idx     = cnt;
    bus.out_last     = last_q;
    bus.overrun_err  = overrun_q;
    bus.mismatch_err = mismatch_q;
  end

endmodule
